// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register map, CTRL bit layout
// and the source-count ceiling.
package irq_ctrl_pkg;

  localparam logic [1:0] ADDR_CTRL = 2'b00;
  localparam logic [1:0] ADDR_MASK = 2'b01;
  localparam logic [1:0] ADDR_PEND = 2'b10;
  localparam logic [1:0] ADDR_MODE = 2'b11;

  localparam int unsigned GIE_BIT    = 0;
  localparam int unsigned ID_LSB     = 8;
  localparam int unsigned ACTIVE_BIT = 15;
  localparam int unsigned ID_W       = 3;
  localparam int unsigned MAX_SRC    = 8;

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Combinational priority encoder: reports the lowest-index set bit of i_act.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned NSRC = 6
) (
  input  logic [NSRC-1:0] i_act,
  output logic            o_valid,
  output logic [ID_W-1:0] o_id
);

  always_comb begin
    o_valid = 1'b0;
    o_id    = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (i_act[i] && !o_valid) begin
        o_valid = 1'b1;
        o_id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller with pending/mask/mode registers on the peripheral bridge.
// Optional macro IRQ_SYNC_EN adds a 2-flop input synchronizer ahead of edge/level sampling.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned NSRC = 6
) (
  input  logic            CLK_I,
  input  logic            RST_N_I,
  input  logic [3:2]      ADD_I,
  input  logic            WE_I,
  input  logic [31:0]     DAT_I,
  output logic [31:0]     DAT_O,
  input  logic [NSRC-1:0] IRQ_I,
  output logic            IRQ_O,
  output logic [2:0]      INT_ID_O
);

  logic            r_gie;
  logic [NSRC-1:0] r_mask;
  logic [NSRC-1:0] r_mode;
  logic [NSRC-1:0] r_pend;
  logic [NSRC-1:0] r_irq_d;

  logic [NSRC-1:0] w_src;
  logic [NSRC-1:0] w_rise;
  logic [NSRC-1:0] w_pend_clr;
  logic [NSRC-1:0] w_mode_chg;
  logic [NSRC-1:0] w_pend_nxt;
  logic [NSRC-1:0] w_act;
  logic            w_valid;
  logic [ID_W-1:0] w_id;
  logic [31:0]     w_ctrl;
  logic            w_unused_dat;

`ifdef IRQ_SYNC_EN
  logic [NSRC-1:0] r_sync1;
  logic [NSRC-1:0] r_sync2;

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= IRQ_I;
      r_sync2 <= r_sync1;
    end
  end

  assign w_src = r_sync2;
`else
  assign w_src = IRQ_I;
`endif

  assign w_rise       = w_src & ~r_irq_d;
  assign w_pend_clr   = (WE_I && ADD_I == ADDR_PEND) ? DAT_I[NSRC-1:0] : '0;
  assign w_mode_chg   = (WE_I && ADD_I == ADDR_MODE) ? (DAT_I[NSRC-1:0] ^ r_mode) : '0;
  assign w_unused_dat = ^DAT_I;

  // Edge sources: a new rising edge beats a same-cycle clear. A MODE flip
  // overrides everything so the source restarts cleanly in its new mode.
  assign w_pend_nxt = ((r_mode & (w_rise | (r_pend & ~w_pend_clr))) |
                       (~r_mode & w_src)) & ~w_mode_chg;

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_gie   <= 1'b0;
      r_mask  <= '0;
      r_mode  <= '0;
      r_pend  <= '0;
      r_irq_d <= '0;
    end else begin
      r_pend  <= w_pend_nxt;
      r_irq_d <= w_src;
      if (WE_I) begin
        case (ADD_I)
          ADDR_CTRL: r_gie  <= DAT_I[GIE_BIT];
          ADDR_MASK: r_mask <= DAT_I[NSRC-1:0];
          ADDR_MODE: r_mode <= DAT_I[NSRC-1:0];
          default:   ;
        endcase
      end
    end
  end

  assign w_act = r_pend & r_mask;

  irq_prio_enc #(
    .NSRC (NSRC)
  ) u_prio_enc (
    .i_act   (w_act),
    .o_valid (w_valid),
    .o_id    (w_id)
  );

  assign IRQ_O    = r_gie & w_valid;
  assign INT_ID_O = IRQ_O ? w_id : '0;

  always_comb begin
    w_ctrl                    = '0;
    w_ctrl[GIE_BIT]           = r_gie;
    w_ctrl[ID_LSB +: ID_W]    = INT_ID_O;
    w_ctrl[ACTIVE_BIT]        = IRQ_O;
  end

  always_comb begin
    DAT_O = '0;
    case (ADD_I)
      ADDR_CTRL: DAT_O = w_ctrl;
      ADDR_MASK: DAT_O = 32'(r_mask);
      ADDR_PEND: DAT_O = 32'(r_pend);
      ADDR_MODE: DAT_O = 32'(r_mode);
      default:   DAT_O = '0;
    endcase
  end

endmodule
